// File: rtl/zynq_aes_perf_pkg.sv
// rtl/zynq_aes_perf_pkg.sv - default widths and saturating add for the zynq_aes performance monitor
package zynq_aes_perf_pkg;

    localparam int unsigned PERF_TS_W  = 32;
    localparam int unsigned PERF_SUM_W = 48;
    localparam int unsigned PERF_CNT_W = 32;
    localparam int unsigned PERF_DEPTH = 8;

    // a + b clamped to the all-ones value of a w-bit register (w <= 64)
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/perf_ts_fifo.sv
// rtl/perf_ts_fifo.sv - timestamp FIFO with wrap-bit pointers and registered head
module perf_ts_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [W-1:0]               din_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [W-1:0]  head_q;
    logic [AW-1:0] rd_nxt;
    logic          push_ok, pop_ok;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign rd_nxt  = rd_ptr_q[AW-1:0] + AW'(1);
    assign head_o  = head_q;

    // storage array, written at the tail on every accepted push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

    // read/write pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // head register: loads the incoming word when it becomes the oldest entry,
    // otherwise the next stored entry after a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
        end else if (clear_i) begin
            head_q <= '0;
        end else if (push_ok && (empty_o || (pop_ok && count_o == PW'(1)))) begin
            head_q <= din_i;
        end else if (pop_ok && count_o > PW'(1)) begin
            head_q <= mem[rd_nxt];
        end
    end

endmodule

// File: rtl/zynq_aes_perf_mon.sv
// rtl/zynq_aes_perf_mon.sv - passive latency monitor for zynq_aes streams; PERF_MON_MINMAX_EN builds min/max tracking
module zynq_aes_perf_mon
    import zynq_aes_perf_pkg::*;
#(
    parameter int unsigned TS_W  = PERF_TS_W,
    parameter int unsigned SUM_W = PERF_SUM_W,
    parameter int unsigned CNT_W = PERF_CNT_W,
    parameter int unsigned DEPTH = PERF_DEPTH
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     clear,
    input  logic                     s_axis_tvalid,
    input  logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    input  logic                     m_axis_tlast,
    output logic                     lat_valid,
    output logic [TS_W-1:0]          lat_last,
    output logic [TS_W-1:0]          lat_min,
    output logic [TS_W-1:0]          lat_max,
    output logic [SUM_W-1:0]         lat_sum,
    output logic [CNT_W-1:0]         req_cnt,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     ovf_err,
    output logic                     unf_err
);

    logic [TS_W-1:0]  ts_q;
    logic             in_pkt_q;
    logic             lat_valid_q;
    logic [TS_W-1:0]  lat_last_q;
    logic [SUM_W-1:0] lat_sum_q;
    logic [CNT_W-1:0] req_cnt_q;
    logic             ovf_q, unf_q;

    logic             s_acc, start, stop;
    logic             fifo_full, fifo_empty;
    logic             bypass, push, pop, valid_stop, ovf_ev, unf_ev;
    logic [TS_W-1:0]  head;
    logic [TS_W-1:0]  lat;

    assign s_acc      = s_axis_tvalid & s_axis_tready;
    assign start      = s_acc & ~in_pkt_q;
    assign stop       = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    // a request that starts and finishes in the same cycle never enters the FIFO
    assign bypass     = start & stop & fifo_empty;
    assign push       = start & ~bypass & (~fifo_full | stop);
    assign pop        = stop & ~fifo_empty;
    assign valid_stop = stop & (~fifo_empty | start);
    assign ovf_ev     = start & fifo_full & ~stop;
    assign unf_ev     = stop & fifo_empty & ~start;
    assign lat        = bypass ? '0 : ts_q - head;

    perf_ts_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .clear_i (clear),
        .push_i  (push),
        .din_i   (ts_q),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding)
    );

    // free-running timebase, wraps naturally
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)   ts_q <= '0;
        else if (clear) ts_q <= '0;
        else            ts_q <= ts_q + TS_W'(1);
    end

    // packet tracking so only the first accepted beat of a request is a start
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)   in_pkt_q <= 1'b0;
        else if (clear) in_pkt_q <= 1'b0;
        else if (s_acc) in_pkt_q <= ~s_axis_tlast;
    end

    // latency sample, accumulated sum and request count
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lat_valid_q <= 1'b0;
            lat_last_q  <= '0;
            lat_sum_q   <= '0;
            req_cnt_q   <= '0;
        end else if (clear) begin
            lat_valid_q <= 1'b0;
            lat_last_q  <= '0;
            lat_sum_q   <= '0;
            req_cnt_q   <= '0;
        end else begin
            lat_valid_q <= valid_stop;
            if (valid_stop) begin
                lat_last_q <= lat;
                lat_sum_q  <= SUM_W'(sat_add(64'(lat_sum_q), 64'(lat), SUM_W));
                req_cnt_q  <= CNT_W'(sat_add(64'(req_cnt_q), 64'd1, CNT_W));
            end
        end
    end

    // sticky error flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_ev) ovf_q <= 1'b1;
            if (unf_ev) unf_q <= 1'b1;
        end
    end

`ifdef PERF_MON_MINMAX_EN
    logic [TS_W-1:0] lat_min_q, lat_max_q;

    // running extremes, min starts at all-ones so the first sample always wins
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lat_min_q <= '1;
            lat_max_q <= '0;
        end else if (clear) begin
            lat_min_q <= '1;
            lat_max_q <= '0;
        end else if (valid_stop) begin
            if (lat < lat_min_q) lat_min_q <= lat;
            if (lat > lat_max_q) lat_max_q <= lat;
        end
    end

    assign lat_min = lat_min_q;
    assign lat_max = lat_max_q;
`else
    assign lat_min = '0;
    assign lat_max = '0;
`endif

    assign lat_valid = lat_valid_q;
    assign lat_last  = lat_last_q;
    assign lat_sum   = lat_sum_q;
    assign req_cnt   = req_cnt_q;
    assign ovf_err   = ovf_q;
    assign unf_err   = unf_q;

endmodule

// File: tb/tb_zynq_aes_perf_mon.sv
// tb/tb_zynq_aes_perf_mon.sv - self-checking bench for zynq_aes_perf_mon (default and narrow instances)
module tb_zynq_aes_perf_mon;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    logic clr = 1'b0;
    logic s_tvalid = 1'b0, s_tready = 1'b0, s_tlast = 1'b0;
    logic m_tvalid = 1'b0, m_tready = 1'b0, m_tlast = 1'b0;

    logic        d_lat_valid, n_lat_valid;
    logic [31:0] d_lat_last, d_lat_min, d_lat_max, d_req_cnt;
    logic [47:0] d_lat_sum;
    logic [3:0]  d_outstanding, n_outstanding;
    logic        d_ovf, d_unf, n_ovf, n_unf;
    logic [7:0]  n_lat_last, n_lat_min, n_lat_max, n_lat_sum, n_req_cnt;

    int tests = 0;
    int fails = 0;
    int pulses = 0;

    always #5 aclk = ~aclk;

    zynq_aes_perf_mon u_dut (
        .aclk(aclk), .aresetn(aresetn), .clear(clr),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .lat_valid(d_lat_valid), .lat_last(d_lat_last), .lat_min(d_lat_min),
        .lat_max(d_lat_max), .lat_sum(d_lat_sum), .req_cnt(d_req_cnt),
        .outstanding(d_outstanding), .ovf_err(d_ovf), .unf_err(d_unf)
    );

    zynq_aes_perf_mon #(.TS_W(8), .SUM_W(8), .CNT_W(8), .DEPTH(8)) u_small (
        .aclk(aclk), .aresetn(aresetn), .clear(clr),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .lat_valid(n_lat_valid), .lat_last(n_lat_last), .lat_min(n_lat_min),
        .lat_max(n_lat_max), .lat_sum(n_lat_sum), .req_cnt(n_req_cnt),
        .outstanding(n_outstanding), .ovf_err(n_ovf), .unf_err(n_unf)
    );

    // reference model: absolute cycle time, a queue of request start times
    longint unsigned now;
    bit              in_pkt;
    longint unsigned q[$];
    bit              e_valid, e_ovf, e_unf;
    longint unsigned e_last32, e_min32, e_max32, e_sum48, e_cnt32;
    longint unsigned e_last8, e_min8, e_max8, e_sum8, e_cnt8;
    localparam longint unsigned MAX48 = 64'h0000_FFFF_FFFF_FFFF;
    localparam longint unsigned MAX32 = 64'h0000_0000_FFFF_FFFF;

    task automatic model_reset();
        now = 0; in_pkt = 0; q.delete();
        e_valid = 0; e_ovf = 0; e_unf = 0;
        e_last32 = 0; e_min32 = MAX32; e_max32 = 0; e_sum48 = 0; e_cnt32 = 0;
        e_last8 = 0; e_min8 = 255; e_max8 = 0; e_sum8 = 0; e_cnt8 = 0;
    endtask

    task automatic record(input longint unsigned l);
        longint unsigned l32, l8;
        l32 = l % (64'd1 << 32);
        l8  = l % 256;
        e_valid = 1; e_last32 = l32; e_last8 = l8;
        if (l32 < e_min32) e_min32 = l32;
        if (l32 > e_max32) e_max32 = l32;
        if (l8 < e_min8) e_min8 = l8;
        if (l8 > e_max8) e_max8 = l8;
        e_sum48 = (e_sum48 + l32 > MAX48) ? MAX48 : e_sum48 + l32;
        e_sum8  = (e_sum8 + l8 > 255) ? 255 : e_sum8 + l8;
        e_cnt32 = (e_cnt32 == MAX32) ? MAX32 : e_cnt32 + 1;
        e_cnt8  = (e_cnt8 == 255) ? 255 : e_cnt8 + 1;
    endtask

    task automatic model_step(input bit sv, sr, sl, mv, mr, ml, c);
        bit acc, start, stop, used;
        longint unsigned h;
        if (c) begin
            model_reset();
            return;
        end
        e_valid = 0;
        acc   = sv & sr;
        start = acc & !in_pkt;
        if (acc) in_pkt = !sl;
        stop  = mv & mr & ml;
        used  = 0;
        if (stop) begin
            if (q.size() != 0) begin
                h = q.pop_front();
                record(now - h);
            end else if (start) begin
                record(0);
                used = 1;
            end else begin
                e_unf = 1;
            end
        end
        if (start && !used) begin
            if (q.size() < 8) q.push_back(now);
            else e_ovf = 1;
        end
        now++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        longint unsigned xmin32, xmax32, xmin8, xmax8;
`ifdef PERF_MON_MINMAX_EN
        xmin32 = e_min32; xmax32 = e_max32; xmin8 = e_min8; xmax8 = e_max8;
`else
        xmin32 = 0; xmax32 = 0; xmin8 = 0; xmax8 = 0;
`endif
        if (d_lat_valid === 1'b1) pulses++;
        chk("lat_valid",   64'(d_lat_valid),   64'(e_valid));
        chk("lat_last",    64'(d_lat_last),    e_last32);
        chk("lat_min",     64'(d_lat_min),     xmin32);
        chk("lat_max",     64'(d_lat_max),     xmax32);
        chk("lat_sum",     64'(d_lat_sum),     e_sum48);
        chk("req_cnt",     64'(d_req_cnt),     e_cnt32);
        chk("outstanding", 64'(d_outstanding), 64'(q.size()));
        chk("ovf_err",     64'(d_ovf),         64'(e_ovf));
        chk("unf_err",     64'(d_unf),         64'(e_unf));
        chk("n_lat_valid", 64'(n_lat_valid),   64'(e_valid));
        chk("n_lat_last",  64'(n_lat_last),    e_last8);
        chk("n_lat_min",   64'(n_lat_min),     xmin8);
        chk("n_lat_max",   64'(n_lat_max),     xmax8);
        chk("n_lat_sum",   64'(n_lat_sum),     e_sum8);
        chk("n_req_cnt",   64'(n_req_cnt),     e_cnt8);
        chk("n_outstanding", 64'(n_outstanding), 64'(q.size()));
        chk("n_ovf_err",   64'(n_ovf),         64'(e_ovf));
        chk("n_unf_err",   64'(n_unf),         64'(e_unf));
    endtask

    task automatic step(input bit sv, sr, sl, mv, mr, ml, c);
        s_tvalid = sv; s_tready = sr; s_tlast = sl;
        m_tvalid = mv; m_tready = mr; m_tlast = ml;
        clr = c;
        model_step(sv, sr, sl, mv, mr, ml, c);
        @(posedge aclk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic start_beat();
        step(1, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic stop_beat();
        step(0, 0, 0, 1, 1, 1, 0);
    endtask

    task automatic do_reset();
        s_tvalid = 0; s_tready = 0; s_tlast = 0;
        m_tvalid = 0; m_tready = 0; m_tlast = 0; clr = 0;
        aresetn = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        #3;
        do_reset();

        // single-beat request: start at ts=10, stop at ts=35
        while (now != 10) idle(1);
        start_beat();
        while (now != 35) idle(1);
        stop_beat();
        chk("t1_valid", 64'(d_lat_valid), 64'd1);
        chk("t1_last",  64'(d_lat_last),  64'd25);
        chk("t1_sum",   64'(d_lat_sum),   64'd25);
        chk("t1_cnt",   64'(d_req_cnt),   64'd1);
`ifdef PERF_MON_MINMAX_EN
        chk("t1_min",   64'(d_lat_min),   64'd25);
        chk("t1_max",   64'(d_lat_max),   64'd25);
`else
        chk("t1_min",   64'(d_lat_min),   64'd0);
        chk("t1_max",   64'(d_lat_max),   64'd0);
`endif

        // four-beat packets with tready 1-high/8-low
        p0 = pulses;
        for (int b = 0; b < 4; b++) begin
            repeat (8) step(1, 0, 0, 0, 0, 0, 0);
            step(1, 1, b == 3, 0, 0, 0, 0);
        end
        for (int b = 0; b < 4; b++) begin
            repeat (8) step(0, 0, 0, 1, 0, 0, 0);
            step(0, 0, 0, 1, 1, b == 3, 0);
        end
        chk("t2_pulses", 64'(pulses - p0), 64'd1);
        chk("t2_last",   64'(d_lat_last),  64'd63);
        chk("t2_cnt",    64'(d_req_cnt),   64'd2);

        // nine starts with growing gaps, then eight back-to-back stops
        for (int i = 0; i < 9; i++) begin
            start_beat();
            idle(i);
        end
        chk("t3_outstanding", 64'(d_outstanding), 64'd8);
        chk("t3_ovf",         64'(d_ovf),         64'd1);
        p0 = pulses;
        for (int i = 0; i < 8; i++) stop_beat();
        idle(1);
        chk("t3_pulses",      64'(pulses - p0),   64'd8);
        chk("t3_drained",     64'(d_outstanding), 64'd0);
        chk("t3_unf",         64'(d_unf),         64'd0);

        // stop with empty FIFO, then same-cycle start and stop
        stop_beat();
        chk("t4_unf",   64'(d_unf),       64'd1);
        chk("t4_noval", 64'(d_lat_valid), 64'd0);
        step(1, 1, 1, 1, 1, 1, 0);
        chk("t4_bypass_valid", 64'(d_lat_valid), 64'd1);
        chk("t4_bypass_last",  64'(d_lat_last),  64'd0);
        chk("t4_bypass_cnt",   64'(d_req_cnt),   64'd11);
        chk("t4_bypass_out",   64'(d_outstanding), 64'd0);

        // clear with three outstanding, colliding with a start and a stop
        repeat (3) start_beat();
        step(1, 1, 1, 1, 1, 1, 1);
        chk("t6_out",   64'(d_outstanding), 64'd0);
        chk("t6_cnt",   64'(d_req_cnt),     64'd0);
        chk("t6_sum",   64'(d_lat_sum),     64'd0);
        chk("t6_ovf",   64'(d_ovf),         64'd0);
        chk("t6_unf",   64'(d_unf),         64'd0);
        chk("t6_valid", 64'(d_lat_valid),   64'd0);
        idle(1);
        stop_beat();
        chk("t6_late_unf", 64'(d_unf), 64'd1);

        // narrow timestamp wrap: start at ts=250, stop at ts=4
        step(0, 0, 0, 0, 0, 0, 1);
        while (now % 256 != 250) idle(1);
        start_beat();
        idle(9);
        stop_beat();
        chk("t5_wrap_n", 64'(n_lat_last), 64'd10);
        chk("t5_wrap_d", 64'(d_lat_last), 64'd10);

        // narrow sum saturation with latencies 200 then 100
        step(0, 0, 0, 0, 0, 0, 1);
        start_beat();
        idle(199);
        stop_beat();
        chk("t5_l200", 64'(n_lat_last), 64'd200);
        start_beat();
        idle(99);
        stop_beat();
        chk("t5_sat_n", 64'(n_lat_sum), 64'd255);
        chk("t5_sum_d", 64'(d_lat_sum), 64'd300);
        chk("t5_cnt_n", 64'(n_req_cnt), 64'd2);

        // reset mid-request discards in-flight timestamps
        start_beat();
        idle(2);
        start_beat();
        p0 = pulses;
        do_reset();
        stop_beat();
        idle(1);
        chk("t7_unf",    64'(d_unf),        64'd1);
        chk("t7_pulses", 64'(pulses - p0),  64'd0);
        chk("t7_cnt",    64'(d_req_cnt),    64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/zynq_aes_perf_mon.md
# zynq_aes_perf_mon

Passive, synthesizable performance monitor for the zynq_aes AXI4-Stream datapath. It taps the input stream (s00) and output stream (m00) handshakes and timestamps the first accepted beat of every input request. It pairs each timestamp with the matching output tlast beat, in FIFO order, and accumulates latency statistics. It generalises the single-request benchmark to DEPTH outstanding requests, with min/max/sum/count statistics and error flags. It sits beside zynq_aes in the block design and never drives the stream.

## Interface
Parameters:
- TS_W, 32: timestamp counter and latency width.
- SUM_W, 48: latency accumulator width.
- CNT_W, 32: request counter width.
- DEPTH, 8: outstanding-request timestamp FIFO depth. Power of 2, ≥2.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of statistics, FIFO and error flags.
- s_axis_tvalid / s_axis_tready / s_axis_tlast  in  1 each  tap of DUT input stream.
- m_axis_tvalid / m_axis_tready / m_axis_tlast  in  1 each  tap of DUT output stream.
- lat_valid  out  1  one-cycle pulse; lat_last holds a new sample.
- lat_last  out  TS_W  most recent request latency, in cycles.
- lat_min / lat_max  out  TS_W  smallest / largest latency since reset or clear.
- lat_sum  out  SUM_W  saturating sum of latencies.
- req_cnt  out  CNT_W  saturating count of completed requests.
- outstanding  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf_err / unf_err  out  1  sticky overflow / underflow flags.

## Operation
- Free-running ts counter: 0 after reset or clear, +1 every cycle, wraps modulo 2^TS_W.
- Input accept: s_axis_tvalid & s_axis_tready.
  - Register in_pkt: set on an accepted beat with tlast=0, cleared on an accepted beat with tlast=1.
  - Start event: an accepted beat while in_pkt=0. It pushes the current ts into the FIFO.
- Stop event: m_axis_tvalid & m_axis_tready & m_axis_tlast. It pops the FIFO head.
- Latency = ts_now − head, modulo 2^TS_W.
- Simultaneous push and pop with the FIFO empty: bypass. Latency 0, occupancy unchanged.
- Simultaneous push and pop with the FIFO non-empty: both happen; occupancy unchanged.
- Push when full, with no simultaneous pop: the timestamp is dropped and ovf_err is set.
- Push when full, with a simultaneous pop: legal; no error.
- Pop when empty, with no simultaneous push: ignored and unf_err is set. No lat_valid, no statistics update.
- On a valid stop, all four statistics update together:
  - lat_min = min(lat_min, L)
  - lat_max = max(lat_max, L)
  - lat_sum = sat(lat_sum + L)
  - req_cnt = sat(req_cnt + 1)
- Addition widths:
  - L is zero-extended to SUM_W before addition.
  - Saturation clamps at all-ones. lat_sum and req_cnt never wrap.
- clear: empties the FIFO, resets in_pkt and ts, and returns all outputs to their reset values. clear wins over a same-cycle push or stop.

## Timing
- Reset values (aresetn low, asynchronous):
  - lat_valid=0, lat_last=0, lat_max=0, lat_sum=0, req_cnt=0, outstanding=0, ovf_err=0, unf_err=0.
  - lat_min=all-ones.
  - ts=0, in_pkt=0.
- Latency timebase: a start on the cycle with ts=T and a stop on the cycle with ts=U give L=U−T.
- Output latency: lat_valid, lat_last and all statistics update on the clock edge that ends the stop cycle. They are visible in the following cycle.
- lat_valid lasts exactly one cycle per valid stop. Back-to-back stops produce back-to-back pulses.
- outstanding and both error flags update on the same edge as the push or pop that changes them.
- Reset asserted mid-request discards all in-flight timestamps. No lat_valid is produced for those requests.

## Configuration
- PERF_MON_MINMAX_EN defined: lat_min and lat_max are tracked as described above.
- PERF_MON_MINMAX_EN undefined:
  - min/max comparators and registers are not built.
  - lat_min and lat_max are tied to 0.
  - All other behaviour is unchanged.

## Structure
- Package zynq_aes_perf_pkg: the default width constants and a function that saturates an addition.
- Sub-module perf_ts_fifo (TS_W × DEPTH):
  - push / pop / full / empty / count ports.
  - Pointers $clog2(DEPTH)+1 bits wide, with the MSB used as the wrap bit.
  - Registered head data.
- Top level: ts counter, in_pkt tracking, bypass/error logic and statistics registers.

## Test plan
- Single-beat request: start at ts=10, output tlast at ts=35 → lat_valid at ts=36, lat_last=25, lat_min=lat_max=lat_sum=25, req_cnt=1.
- Four-beat input packet then four-beat output packet, with tready oscillating 1-high/8-low → exactly one push, one lat_valid, latency equal to first-accept-to-tlast-accept.
- DEPTH=8: issue 9 starts with no stops → outstanding=8, ovf_err=1. Then 8 stops → 8 lat_valid pulses in FIFO order, outstanding=0, unf_err=0.
- Output tlast with the FIFO empty → unf_err=1, no lat_valid. Same-cycle start and stop with the FIFO empty → lat_last=0, req_cnt+1, no error.
- TS_W=8: start at ts=250, stop at ts=4 (after wrap) → lat_last=10. SUM_W=8 with latencies 200 then 100 → lat_sum=255 (saturated).
- Assert clear with 3 outstanding requests → all outputs at reset values the next cycle, and a later stop sets unf_err. Build without PERF_MON_MINMAX_EN → lat_min=lat_max=0 throughout.
